// File: rtl/bist_pkg.sv
// Shared types and constants for the logic-BIST pattern generator.
package bist_pkg;

    localparam int BIST_WIDTH  = 36;
    localparam int LFSR_TAP_HI = 35;
    localparam int LFSR_TAP_LO = 24;

    localparam logic [BIST_WIDTH-1:0] BIST_DEFAULT_SEED = 36'h0_0000_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

endpackage

// File: rtl/bist_lfsr36.sv
// 36-bit Fibonacci LFSR (x^36 + x^25 + 1) with seed load and shift enable.
// An all-zero seed is replaced by 1 so the register can never lock up.
module bist_lfsr36
    import bist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [BIST_WIDTH-1:0] i_seed,
    output logic [BIST_WIDTH-1:0] o_q
);

    logic [BIST_WIDTH-1:0] r_q;
    logic [BIST_WIDTH-1:0] w_seed_eff;
    logic                  w_fb;

    assign w_seed_eff = (i_seed == '0) ? BIST_WIDTH'(1) : i_seed;
    assign w_fb       = r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO];

    // Load has priority so a restart always begins from the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= w_seed_eff;
        end else if (i_shift) begin
            r_q <= {r_q[BIST_WIDTH-2:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bist_tpg.sv
// BIST pattern generator and run controller; BIST_TPG_SEED_PORT_EN adds a
// seed_in port sampled on the start cycle in place of the SEED parameter.
//
// state | meaning
// IDLE  | mux deselected, waiting for start
// RUN   | one counted pattern per cycle, bist=1
// DONE  | run complete, done sticky until start or abort
module bist_tpg
    import bist_pkg::*;
#(
    parameter int                    WIDTH        = BIST_WIDTH,
    parameter logic [BIST_WIDTH-1:0] NUM_PATTERNS = 36'd1024,
    parameter logic [BIST_WIDTH-1:0] SEED         = BIST_DEFAULT_SEED,
    localparam int                   CNT_W        = $clog2({1'b0, NUM_PATTERNS} + 37'd1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef BIST_TPG_SEED_PORT_EN
    input  logic [WIDTH-1:0] seed_in,
`endif
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             bist,
    output logic             done,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 36'd1);

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_lfsr_q;

`ifdef BIST_TPG_SEED_PORT_EN
    assign w_seed = seed_in;
`else
    assign w_seed = SEED;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_shift = (r_state == RUN);

    // Flags are registered from the next state so bist and pattern_valid
    // switch on the same edge as the pattern they qualify.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
            if (w_load) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    bist_lfsr36 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_seed  (w_seed),
        .o_q     (w_lfsr_q)
    );

    assign pattern       = w_lfsr_q;
    assign pattern_valid = r_run;
    assign bist          = r_run;
    assign done          = r_done;
    assign pattern_cnt   = r_cnt;

endmodule
